// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge: FSM states, the
// registered response record and the word-alignment helper.
package apb_master_pkg;

  localparam int ADDR_ALIGN_BITS = 2;
  localparam int DATA_W          = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } apb_mst_rsp_t;

  function automatic logic is_misaligned(input logic [ADDR_ALIGN_BITS-1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/apb_master_watchdog.sv
// ACCESS-phase timeout counter for the APB master bridge; only instantiated
// when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (busy && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires in the stall cycle that takes the count to its limit; busy already
  // excludes PREADY, so a completion in that same cycle takes priority.
  assign expired = busy && (r_count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding core-to-APB master bridge with alignment check.
// Define APB_MASTER_TIMEOUT_EN to add the ACCESS-phase watchdog.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_AW         = 32,
  parameter int APB_DW         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [APB_AW-1:0] req_addr,
  input  logic [APB_DW-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_mst_state_e    r_state;
  apb_mst_state_e    w_next;
  logic              r_write;
  logic [APB_AW-1:0] r_addr;
  logic [APB_DW-1:0] r_wdata;
  apb_mst_rsp_t      r_rsp;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_expired;

  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_misaligned = is_misaligned(req_addr[ADDR_ALIGN_BITS-1:0]);

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_wd_start;
  logic w_wd_busy;

  assign w_wd_start = (r_state == SETUP);
  assign w_wd_busy  = (r_state == ACCESS) && !PREADY;

  apb_master_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (w_wd_start),
    .busy   (w_wd_busy),
    .expired(w_expired)
  );
`else
  // No watchdog: a constant-false expiry, so ACCESS waits for PREADY forever.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = w_misaligned ? RESP : SETUP;
        end
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY || w_expired) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // PREADY is checked before the watchdog so a last-moment completion wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp <= '0;
    end else if (w_accept && w_misaligned) begin
      r_rsp.rdata <= '0;
      r_rsp.err   <= 1'b1;
    end else if ((r_state == ACCESS) && PREADY) begin
      r_rsp.err   <= PSLVERR;
      r_rsp.rdata <= (!r_write && !PSLVERR) ? PRDATA : '0;
    end else if ((r_state == ACCESS) && w_expired) begin
      r_rsp.rdata <= '0;
      r_rsp.err   <= 1'b1;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign PSEL      = (r_state == SETUP) || (r_state == ACCESS);
  assign PENABLE   = (r_state == ACCESS);
  assign PWRITE    = r_write;
  assign PADDR     = r_addr;
  assign PWDATA    = r_wdata;
  assign rsp_rdata = r_rsp.rdata;
  assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard testbench for apb_master_bridge with a behavioural APB slave.
// The timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [32:0] sbQ[$];

  int          slvWait;
  logic [31:0] slvData;
  logic        slvErr;
  logic        slvStuck;

  apb_master_bridge #(
    .APB_AW        (32),
    .APB_DW        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Slave: PREADY after slvWait extra ACCESS cycles; garbage on PRDATA/PSLVERR otherwise.
  initial begin
    int accCnt;
    accCnt  = 0;
    PREADY  = 1'b0;
    PRDATA  = 32'hBAD0_BAD0;
    PSLVERR = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (PSEL && PENABLE) accCnt++;
      else accCnt = 0;
      if (PSEL && PENABLE && !slvStuck && (accCnt > slvWait)) begin
        PREADY  = 1'b1;
        PRDATA  = slvData;
        PSLVERR = slvErr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 32'hBAD0_BAD0;
        PSLVERR = 1'b1;
      end
    end
  end

  // Monitor: every response handshake is checked against the oldest expectation.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("rsp_rdata", rsp_rdata, exp[32:1]);
          checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, exp[0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] global timeout");
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expR, input logic expE, input logic expectRsp);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (expectRsp) sbQ.push_back({expR, expE});
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: got req_ready 0, expected 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic traceCycles(input int n, output logic [7:0] pselTr, output logic [7:0] penTr,
                             output logic [7:0] rvTr);
    pselTr = '0;
    penTr  = '0;
    rvTr   = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pselTr[k] = PSEL;
      penTr[k]  = PENABLE;
      rvTr[k]   = rsp_valid;
    end
  endtask

  task automatic drainScoreboard(input string name);
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(name, sbQ.size(), 0);
    @(negedge clk);
  endtask

  task automatic countAccessCycles(output int accessCycles, output int unstable,
                                   input logic [31:0] expAddr, input logic expWrite);
    int guard;
    accessCycles = 0;
    unstable     = 0;
    guard        = 0;
    while (guard < 40) begin
      @(negedge clk);
      guard++;
      if (rsp_valid) break;
      if (PENABLE) accessCycles++;
      if (PSEL && (PADDR !== expAddr || PWRITE !== expWrite)) unstable++;
    end
  endtask

  task automatic stallCheck();
    int guard;
    int violations;
    guard      = 0;
    violations = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_rdata == 32'h0BAD_F00D && !req_ready && !PSEL)) violations++;
    end
    checkOutput("stall_hold", violations, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] pselTr;
    logic [7:0] penTr;
    logic [7:0] rvTr;
    int         accessCycles;
    int         unstable;
    int         violations;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    slvWait   = 0;
    slvData   = '0;
    slvErr    = 1'b0;
    slvStuck  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_ready_valid", {30'b0, req_ready, rsp_valid}, 32'h2);
    checkOutput("reset_apb_ctrl", {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
    checkOutput("reset_paddr", PADDR, 32'h0);
    checkOutput("reset_pwdata", PWDATA, 32'h0);
    checkOutput("reset_rsp", rsp_rdata | {31'b0, rsp_err}, 32'h0);

    // Write with one wait state: response lands four cycles after accept.
    slvWait = 1;
    applyStimulus(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    checkOutput("wr_pwrite", {31'b0, PWRITE}, 32'h1);
    checkOutput("wr_paddr", PADDR, 32'h0000_0104);
    checkOutput("wr_pwdata", PWDATA, 32'hCAFE_F00D);
    traceCycles(4, pselTr, penTr, rvTr);
    checkOutput("wr_psel_trace", {24'b0, pselTr}, 32'h07);
    checkOutput("wr_penable_trace", {24'b0, penTr}, 32'h06);
    checkOutput("wr_rspvalid_trace", {24'b0, rvTr}, 32'h08);
    drainScoreboard("wr_drain");

    // Read with two wait states; APB outputs must hold through ACCESS.
    slvWait = 2;
    slvData = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h0000_0208, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    countAccessCycles(accessCycles, unstable, 32'h0000_0208, 1'b0);
    checkOutput("rd_access_cycles", accessCycles, 3);
    checkOutput("rd_apb_stable", unstable, 0);
    drainScoreboard("rd_drain");

    // Slave error on a read, then normal traffic resumes.
    slvWait = 0;
    slvErr  = 1'b1;
    slvData = 32'h5555_AAAA;
    applyStimulus(1'b0, 32'h0000_020C, 32'h0, 32'h0, 1'b1, 1'b1);
    drainScoreboard("slverr_drain");
    slvErr  = 1'b0;
    slvData = 32'h7777_8888;
    applyStimulus(1'b1, 32'h0000_0300, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    slvData = 32'h1357_9BDF;
    applyStimulus(1'b0, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    drainScoreboard("after_err_drain");

    // Misaligned: immediate error response, no APB activity.
    applyStimulus(1'b1, 32'h0000_0102, 32'hFFFF_0000, 32'h0, 1'b1, 1'b1);
    traceCycles(3, pselTr, penTr, rvTr);
    checkOutput("mis_psel_trace", {24'b0, pselTr}, 32'h00);
    checkOutput("mis_rspvalid_trace", {24'b0, rvTr}, 32'h01);
    drainScoreboard("mis_drain");

    // Response back-pressure with a second request waiting.
    slvWait   = 1;
    slvData   = 32'h0BAD_F00D;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    fork
      applyStimulus(1'b1, 32'h0000_0500, 32'h600D_CAFE, 32'h0, 1'b0, 1'b1);
      stallCheck();
    join
    drainScoreboard("stall_drain");

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: watchdog aborts after eight ACCESS cycles.
    slvStuck = 1'b1;
    applyStimulus(1'b0, 32'h0000_0700, 32'h0, 32'h0, 1'b1, 1'b1);
    countAccessCycles(accessCycles, unstable, 32'h0000_0700, 1'b0);
    checkOutput("to_access_cycles", accessCycles, 8);
    checkOutput("to_psel_dropped", {31'b0, PSEL}, 32'h0);
    drainScoreboard("to_drain");
    slvStuck = 1'b0;
`endif

    // Reset while in ACCESS: APB controls drop at once, no response follows.
    slvStuck = 1'b1;
    applyStimulus(1'b0, 32'h0000_0600, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_access", {30'b0, PSEL, PENABLE}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_apb", {30'b0, PSEL, PENABLE}, 32'h0);
    checkOutput("rst_async_rspvalid", {31'b0, rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    slvStuck = 1'b0;
    violations = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || !req_ready || PSEL) violations++;
    end
    checkOutput("rst_no_rsp", violations, 0);
    checkOutput("rst_paddr_cleared", PADDR, 32'h0);

    slvWait = 0;
    slvData = 32'hA5A5_5A5A;
    applyStimulus(1'b0, 32'h0000_0800, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b1);
    drainScoreboard("final_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
